pkt_merge_arb: RTL

- Packet-atomic two-input arbiter for the packet-merge datapath.
- Sits between the two 153-bit single-clock input FIFOs (iport0/iport1 side) and the merged output port.
- Drives each FIFO's dequeue strobe and holds the selected beat in a one-entry output register.
- Round-robin between inputs at packet boundaries only; beats of different packets are never interleaved.

---
 rtl/pkt_merge_pkg.sv | 13 +
 rtl/pkt_rr_arb2.sv | 14 +
 rtl/pkt_merge_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/pkt_merge_pkg.sv
// Shared constants, FSM state encoding and beat type for the packet-merge arbiter.
package pkt_merge_pkg;

    localparam int DW      = 153;
    localparam int EOP_BIT = 152;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL0 = 2'd1;
    localparam logic [1:0] ST_SEL1 = 2'd2;

    typedef logic [DW-1:0] beat_t;

endpackage

// File: rtl/pkt_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the input
// that did not win last. Purely combinational; last_grant is held by the parent.
module pkt_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) gnt = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/pkt_merge_arb.sv
// Packet-atomic two-input merge arbiter with a one-entry output register.
// Optional per-input packet counters are built when PKT_MERGE_ARB_STATS_EN is defined.
module pkt_merge_arb #(
    parameter int DW      = pkt_merge_pkg::DW,
    parameter int EOP_BIT = pkt_merge_pkg::EOP_BIT,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [DW-1:0]    fi0_D_OUT,
    input  logic             fi0_EMPTY_N,
    output logic             fi0_DEQ,
    input  logic [DW-1:0]    fi1_D_OUT,
    input  logic             fi1_EMPTY_N,
    output logic             fi1_DEQ,
    output logic [DW-1:0]    oport_get,
    output logic             RDY_oport_get,
    input  logic             EN_oport_get,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);
    import pkt_merge_pkg::*;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          out_full_q, out_full_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    gnt;
    logic          src_vld, src, src_rdy, can_load, xfer, eop;
    logic [DW-1:0] src_beat;

    pkt_rr_arb2 u_arb (
        .req        ({fi1_EMPTY_N, fi0_EMPTY_N}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    // Once a packet has started, the source stays locked until its EOP beat.
    always_comb begin
        src_vld = 1'b0;
        src     = 1'b0;
        case (state_q)
            ST_IDLE: begin src_vld = |gnt; src = gnt[1]; end
            ST_SEL0: begin src_vld = 1'b1; src = 1'b0;   end
            ST_SEL1: begin src_vld = 1'b1; src = 1'b1;   end
            default: ;
        endcase
    end

    assign src_rdy  = src ? fi1_EMPTY_N : fi0_EMPTY_N;
    assign src_beat = src ? fi1_D_OUT   : fi0_D_OUT;
    assign can_load = !out_full_q || EN_oport_get;
    assign xfer     = src_vld && src_rdy && can_load;
    assign eop      = src_beat[EOP_BIT];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (xfer)
            state_d = eop ? ST_IDLE : (src ? ST_SEL1 : ST_SEL0);
        else if (state_q != ST_IDLE && state_q != ST_SEL0 && state_q != ST_SEL1)
            state_d = ST_IDLE;
    end

    // Strobes are forced low during reset even though the FIFOs may still show data.
    always_comb begin
        fi0_DEQ = RST_N && xfer && !src;
        fi1_DEQ = RST_N && xfer &&  src;
    end

    assign last_grant_d = (xfer && eop) ? src : last_grant_q;
    assign out_full_d   = xfer || (out_full_q && !EN_oport_get);
    assign data_d       = xfer ? src_beat : data_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant_q <= 1'b1;
            out_full_q   <= 1'b0;
            data_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            out_full_q   <= out_full_d;
            data_q       <= data_d;
        end
    end

    assign oport_get     = data_q;
    assign RDY_oport_get = out_full_q;

`ifdef PKT_MERGE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (xfer && eop && !src) cnt0_q <= cnt0_q + CNT_W'(1);
            if (xfer && eop &&  src) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif

endmodule
